// File: rtl/instr_seq.sv
// instr_seq: fetch/issue sequencer feeding the proc core one instruction at a time.
// Optional retired-instruction counter enabled by INSTR_SEQ_RETIRE_CNT_EN.
module instr_seq #(
    parameter int AW = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic [AW-1:0] StartAddr,
    input  logic          Halt,
    output logic [AW-1:0] MemAddr,
    output logic          MemRd,
    input  logic [15:0]   MemData,
    output logic [15:0]   DIN,
    output logic          Run,
    input  logic          Done,
    output logic          Busy,
    output logic          Halted,
    output logic [AW-1:0] PC,
    output logic [15:0]   Retired
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, EXEC} state_t;
    state_t state, state_nx;
    logic [AW-1:0] pc;
    logic [15:0] din_q;
    logic halted, halt_q;
    logic halt_op, run, accept, retire;
    assign halt_op = MemData[15:13] == 3'b111;
    assign run     = state == ISSUE && !halt_op;
    assign accept  = state == IDLE && Start;
    assign retire  = state == EXEC && Done;
    assign MemAddr = pc;
    assign PC      = pc;
    assign MemRd   = state == FETCH;
    assign Busy    = state != IDLE;
    assign Halted  = halted;
    assign Run     = run;
    assign DIN     = run ? MemData : din_q;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = Start ? FETCH : IDLE;
            FETCH:   state_nx = ISSUE;
            ISSUE:   state_nx = halt_op ? IDLE : EXEC;
            EXEC:    state_nx = !Done ? EXEC : (halt_q || Halt) ? IDLE : FETCH;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            pc     <= '0;
            din_q  <= '0;
            halted <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            state  <= state_nx;
            pc     <= accept ? StartAddr : retire ? pc + 1'b1 : pc;
            din_q  <= run ? MemData : din_q;
            halted <= accept ? 1'b0 : (state == ISSUE && halt_op) ? 1'b1 : halted;
            // a Halt coinciding with Done is folded into the EXEC exit decision
            halt_q <= state_nx == IDLE ? 1'b0 : (Halt && state != IDLE) ? 1'b1 : halt_q;
        end
    end
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            retired <= '0;
        else
            retired <= accept ? 16'h0000 : (retire && retired != 16'hFFFF) ? retired + 1'b1 : retired;
    end
    assign Retired = retired;
`else
    assign Retired = 16'h0000;
`endif
endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: sequencer bench with instruction memory, proc core model and program-level reference.
module tb_instr_seq;
    localparam int AW = 8;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    logic Clock = 1'b0, Resetn = 1'b1, Start = 1'b0, Halt = 1'b0;
    logic [AW-1:0] StartAddr = '0, MemAddr, PC;
    logic MemRd, Run, Done, Busy, Halted;
    logic [15:0] MemData, DIN, Retired;

    always #5 Clock = ~Clock;

    instr_seq #(.AW(AW)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .StartAddr(StartAddr), .Halt(Halt),
        .MemAddr(MemAddr), .MemRd(MemRd), .MemData(MemData), .DIN(DIN), .Run(Run),
        .Done(Done), .Busy(Busy), .Halted(Halted), .PC(PC), .Retired(Retired)
    );

    logic [15:0] mem [256];
    logic [15:0] mem_q;
    always @(posedge Clock) if (MemRd) mem_q <= mem[MemAddr];
    assign MemData = mem_q;

    // core model: mv/mvt finish in the first step after issue, add/sub in the third
    logic [15:0] r [8] = '{default: 16'h0};
    logic cbusy = 1'b0;
    int ccnt = 0, cneed = 1;
    assign Done = cbusy && ccnt == cneed - 1;
    function automatic logic [15:0] core_result(input logic [15:0] w);
        logic [15:0] opd;
        opd = w[12] ? {7'b0, w[8:0]} : r[w[2:0]];
        case (w[15:13])
            3'd0: return opd;
            3'd1: return {w[7:0], 8'h00};
            3'd2: return r[w[11:9]] + opd;
            3'd3: return r[w[11:9]] - opd;
            default: return r[w[11:9]];
        endcase
    endfunction
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cbusy <= 1'b0;
            ccnt  <= 0;
        end else if (Run) begin
            cbusy <= 1'b1;
            ccnt  <= 0;
            cneed <= DIN[15:13] < 3'd2 ? 1 : 3;
        end else if (cbusy) begin
            if (Done) begin
                cbusy <= 1'b0;
                r[DIN[11:9]] <= core_result(DIN);
            end else
                ccnt <= ccnt + 1;
        end
    end

    int cyc = 0, runs = 0;
    int run_at[$];
    always @(negedge Clock) begin
        cyc++;
        if (Run) begin
            runs++;
            run_at.push_back(cyc);
        end
    end

    int vecs = 0, bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    logic [15:0] prog[$];
    task automatic load_prog(input logic [7:0] s);
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
        foreach (prog[i]) mem[8'(s + 8'(i))] = prog[i];
    endtask

    task automatic start_at(input logic [7:0] s);
        StartAddr = s;
        Start = 1'b1;
        step;
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (Busy && n < budget) begin
            step;
            n++;
        end
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (!Run && n < 20) begin
            step;
            n++;
        end
        if (!Run) chk({name, "_run_timeout"}, 0, 1);
    endtask

    typedef struct {
        logic [7:0] start;
        int n;
        logic [3:0][15:0] w;
        logic [7:0] pc;
        int runs;
        int cyc;
        int ri;
        logic [15:0] rv;
    } vec_t;
    function automatic vec_t mkv(input logic [7:0] s, input int n, input logic [15:0] w0, w1, w2,
                                 input logic [7:0] pc, input int rn, cy, ri, input logic [15:0] rv);
        vec_t v;
        v.start = s; v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = 16'hE000;
        v.pc = pc; v.runs = rn; v.cyc = cy; v.ri = ri; v.rv = rv;
        return v;
    endfunction

    initial begin
        vec_t tv[5];
        int n;
        logic [7:0] s;
        logic [15:0] mr [8];
        logic [15:0] w, opd;
        int ecyc, op;
        logic rd_seen, reg_ok;
        // mv r0,#5 ; add r0,#3 ; HALT
        tv[0] = mkv(8'h00, 2, 16'h1005, 16'h5003, 16'hE000, 8'h02, 2, 10, 0, 16'd8);
        // mv r1,#1 at 255, HALT at 0 (PC wraps)
        tv[1] = mkv(8'hFF, 1, 16'h1201, 16'hE000, 16'hE000, 8'h00, 1, 5, 1, 16'd1);
        // mvt r3,#0x12 ; sub r3,#2
        tv[2] = mkv(8'h40, 2, 16'h3612, 16'h7602, 16'hE000, 8'h42, 2, 10, 3, 16'h11FE);
        // mv r4,#9 ; mv r5,r4 ; add r5,r4
        tv[3] = mkv(8'h80, 3, 16'h1809, 16'h0A04, 16'h4A04, 8'h83, 3, 13, 5, 16'd18);
        // HALT as the first word
        tv[4] = mkv(8'h10, 0, 16'hE000, 16'hE000, 16'hE000, 8'h10, 0, 2, 4, 16'd9);

        #1 Resetn = 1'b0;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_pc", PC, 0);
        chk("rst_memrd", MemRd, 0);
        chk("rst_run", Run, 0);
        chk("rst_din", DIN, 0);
        chk("rst_retired", Retired, 0);
        step;
        step;
        Resetn = 1'b1;
        Halt = 1'b1;
        step;
        Halt = 1'b0;
        chk("idle_halt_ignored", {Busy, Halted}, 0);

        for (int i = 0; i < 5; i++) begin
            prog.delete();
            for (int k = 0; k < tv[i].n; k++) prog.push_back(tv[i].w[k]);
            load_prog(tv[i].start);
            runs = 0;
            run_at.delete();
            start_at(tv[i].start);
            wait_idle(60, n);
            chk($sformatf("v%0d_cycles", i), n, tv[i].cyc);
            chk($sformatf("v%0d_pc", i), PC, tv[i].pc);
            chk($sformatf("v%0d_halted", i), Halted, 1);
            chk($sformatf("v%0d_runs", i), runs, tv[i].runs);
            chk($sformatf("v%0d_reg", i), r[tv[i].ri], tv[i].rv);
            chk($sformatf("v%0d_retired", i), Retired, RC ? tv[i].n : 0);
            if (i == 0) chk("v0_run_gap", run_at.size() >= 2 ? run_at[1] - run_at[0] : 0, 3);
        end

        // restart clears the retired count and Halted
        prog = '{16'h1005, 16'h5003};
        load_prog(8'h00);
        start_at(8'h00);
        wait_idle(60, n);
        chk("rs_retired_before", Retired, RC ? 2 : 0);
        start_at(8'h00);
        chk("rs_retired_after", Retired, 0);
        chk("rs_halted_cleared", Halted, 0);
        wait_idle(60, n);

        // Halt during EXEC of an add at 4
        prog = '{16'h5003, 16'h1005};
        load_prog(8'h04);
        runs = 0;
        start_at(8'h04);
        wait_run("hx");
        step;
        Halt = 1'b1;
        step;
        Halt = 1'b0;
        wait_idle(20, n);
        chk("hx_pc", PC, 5);
        chk("hx_state", {Busy, Halted}, 0);
        chk("hx_runs", runs, 1);

        // Halt in the same cycle as Done
        prog = '{16'h1005, 16'h1005};
        load_prog(8'h08);
        start_at(8'h08);
        wait_run("hd");
        step;
        chk("hd_done", Done, 1);
        Halt = 1'b1;
        step;
        Halt = 1'b0;
        chk("hd_busy", Busy, 0);
        chk("hd_pc", PC, 9);
        rd_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd_seen |= MemRd;
            step;
        end
        chk("hd_no_memrd", rd_seen, 0);

        // Start during EXEC is ignored
        prog = '{16'h1407, 16'h5401};
        load_prog(8'h0C);
        runs = 0;
        start_at(8'h0C);
        wait_run("sx");
        step;
        step;
        wait_run("sx2");
        step;
        StartAddr = 8'h00;
        Start = 1'b1;
        step;
        Start = 1'b0;
        wait_idle(30, n);
        chk("sx_pc", PC, 8'h0E);
        chk("sx_r2", r[2], 16'd8);
        chk("sx_runs", runs, 2);
        chk("sx_halted", Halted, 1);

        // reset in the middle of an add
        start_at(8'h0C);
        wait_run("rx");
        step;
        step;
        wait_run("rx2");
        step;
        #2 Resetn = 1'b0;
        #1;
        chk("rx_pc", PC, 0);
        chk("rx_memaddr", MemAddr, 0);
        chk("rx_busy", Busy, 0);
        chk("rx_run_memrd", {Run, MemRd}, 0);
        chk("rx_halted", Halted, 0);
        chk("rx_din", DIN, 0);
        chk("rx_retired", Retired, 0);
        step;
        Resetn = 1'b1;
        step;
        chk("rx_idle_after", {Busy, MemRd}, 0);

        // random programs against a program-level reference
        mr = r;
        for (int it = 0; it < 20; it++) begin
            s = 8'($urandom);
            n = $urandom_range(1, 6);
            ecyc = 2;
            prog.delete();
            for (int k = 0; k < n; k++) begin
                op = $urandom_range(0, 3);
                w = {3'(op), 1'($urandom), 3'($urandom), 9'($urandom)};
                prog.push_back(w);
                opd = w[12] ? 16'(w[8:0]) : mr[w[2:0]];
                if (op == 0) mr[w[11:9]] = opd;
                else if (op == 1) mr[w[11:9]] = 16'(w[7:0]) * 256;
                else if (op == 2) mr[w[11:9]] = mr[w[11:9]] + opd;
                else mr[w[11:9]] = mr[w[11:9]] - opd;
                ecyc += op < 2 ? 3 : 5;
            end
            load_prog(s);
            runs = 0;
            start_at(s);
            wait_idle(100, op);
            reg_ok = 1'b1;
            for (int k = 0; k < 8; k++) reg_ok &= (r[k] === mr[k]);
            chk($sformatf("rnd%0d_cycles", it), op, ecyc);
            chk($sformatf("rnd%0d_pc", it), PC, 8'(s + 8'(n)));
            chk($sformatf("rnd%0d_runs", it), runs, n);
            chk($sformatf("rnd%0d_regs", it), reg_ok, 1);
            chk($sformatf("rnd%0d_halted", it), Halted, 1);
            chk($sformatf("rnd%0d_retired", it), Retired, RC ? n : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/instr_seq.md
# instr_seq

Instruction fetch/issue sequencer for the 16-bit `proc` core. It owns the program counter and reads instruction words from a synchronous-read instruction memory. It presents each word on the core's `DIN` with a one-cycle `Run` pulse, then waits for `Done` before fetching the next word. It also stops the core on software or host request.

## Interface
Parameters:
- `AW`, 8: instruction memory address width; PC width.

Ports:
- `Clock`  in  1: sole clock; all state changes on its rising edge.
- `Resetn`  in  1: asynchronous, active-low reset.
- `Start`  in  1: one-cycle pulse; begins execution at `StartAddr`; honoured only in IDLE.
- `StartAddr`  in  AW: first instruction address, sampled when `Start` is accepted.
- `Halt`  in  1: host stop request; stops after the in-flight instruction completes.
- `MemAddr`  out  AW: instruction memory address.
- `MemRd`  out  1: memory read strobe; data is valid on `MemData` the next cycle.
- `MemData`  in  16: instruction word from memory.
- `DIN`  out  16: instruction to the core; held stable from ISSUE until the next ISSUE.
- `Run`  out  1: one-cycle issue pulse to the core.
- `Done`  in  1: core completion, combinational from the core's final time step.
- `Busy`  out  1: high in any state other than IDLE.
- `Halted`  out  1: set when a HALT opcode is fetched; cleared by an accepted `Start`.
- `PC`  out  AW: address of the current or next instruction.
- `Retired`  out  16: retired-instruction count (see Configuration).

## Operation
- States: IDLE, FETCH, ISSUE, EXEC.
- IDLE:
  - `Start` → PC <= `StartAddr`, clear `Halted` and the halt latch, go to FETCH.
  - `Halt` in IDLE is ignored.
- FETCH: `MemRd`=1, `MemAddr`=PC → ISSUE.
- ISSUE: `MemData` is valid this cycle.
  - If `MemData[15:13]`==3'b111 (reserved opcode, defined here as HALT): no `Run`, set `Halted`, PC unchanged, go to IDLE.
  - Otherwise: `Run`=1, `DIN`=`MemData` driven combinationally and captured into the `DIN` holding register, go to EXEC.
- EXEC: `Run`=0; stay in EXEC until `Done`=1. On `Done`:
  - PC <= PC+1, modulo 2^AW (wraps to 0 after 2^AW-1).
  - Halt latch set → IDLE. Otherwise → FETCH.
- Halt latch:
  - Set by `Halt`=1 in FETCH, ISSUE or EXEC.
  - Cleared when entering IDLE.
  - `Halt` and `Done` asserted in the same EXEC cycle: the halt is honoured, PC still advances, next state is IDLE.
- `Start` outside IDLE is ignored, with no effect on PC or state.
- `MemAddr`=PC in every state; `MemRd` is high only in FETCH.
- Reset (asynchronous, any state, including mid-EXEC): state=IDLE, PC=0, `DIN`=0, halt latch=0. All outputs go to 0: `MemRd`, `MemAddr`, `Run`, `Busy`, `Halted`, `PC`, `Retired`.
- The system drives the core's reset from the same reset source, so the two stay aligned.

## Timing
- `Start` accepted at edge k: FETCH in cycle k+1, ISSUE (`Run`) in k+2.
- `Done` is sampled in the cycle immediately after ISSUE, matching the core's first execution step.
- Instruction length, from FETCH to the `Done` cycle inclusive:
  - mv, mvt: 3 cycles.
  - add, sub: 5 cycles.
- Back-to-back: FETCH of the next word occurs in the cycle after `Done`, while the core is back in its fetch step.
- No combinational path from `Done` or `MemData` to `MemAddr`/`MemRd`.
- The only combinational paths are `MemData`→`DIN` and `MemData`→`Run`, both in ISSUE.

## Configuration
- `INSTR_SEQ_RETIRE_CNT_EN` defined:
  - `Retired` is a 16-bit counter, incremented on each EXEC `Done`, saturating at 16'hFFFF.
  - Cleared by reset and by an accepted `Start`.
  - HALT opcodes are not counted.
- Undefined: `Retired` is tied to 16'h0000 and no counter logic is built.

## Test plan
- Program at 0: `mv r0,#5`; `add r0,#3`; HALT (16'hE000); `Start` with `StartAddr`=0.
  - `Run` pulses exactly twice, 3 cycles apart.
  - `Halted`=1 with PC=2, 10 cycles after `Start`.
  - Core r0=8; `Retired`=2 (macro on).
- `Halt` pulse during EXEC of an `add` at address 4: core completes the add, then state is IDLE, PC=5, `Halted`=0, `Busy`=0.
- `Halt` asserted in the same cycle as `Done`: PC advances by 1, IDLE next cycle, no further `MemRd`.
- AW=4, `StartAddr`=15, word 15 = `mv r1,#1`, word 0 = HALT: PC wraps 15→0, HALT is fetched from 0, r1=1.
- `Start` pulsed during EXEC: ignored, PC and sequence unchanged.
- Then `Resetn` low mid-EXEC: all outputs read 0 within the reset cycle, and the state is IDLE after release.
- Macro off: same program as the first scenario gives `Retired`=0 throughout.
- Macro on: run 2 instructions, then restart with `Start`; `Retired` returns to 0 on restart.
